// File: rtl/nmr_bstrm_pkg.sv
// Shared definitions for the NMR bitstream path: read owner, word field
// positions and default widths.
package nmr_bstrm_pkg;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_ENG  = 1'b1
  } owner_e;

  // One in-flight read: whether the slot holds a read and who issued it.
  typedef struct packed {
    logic   vld;
    owner_e own;
  } rd_tag_t;

  localparam int EOS_BIT      = 127;
  localparam int LOOP_STA_BIT = 126;
  localparam int LOOP_STO_BIT = 125;
  localparam int PATTERN_BIT  = 124;
  localparam int ALL1_BIT     = 123;
  localparam int ALL0_BIT     = 122;
  localparam int DATA_MSB     = 119;
  localparam int DATA_LSB     = 0;

  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_DAT_WIDTH    = 128;
  localparam int DEF_BYTEEN_WIDTH = 16;
  localparam int DEF_RD_LAT       = 2;

  // Control flags of a sequence word, EOS in the MSB.
  function automatic logic [5:0] word_flags(input logic [DEF_DAT_WIDTH-1:0] w);
    return w[EOS_BIT:ALL0_BIT];
  endfunction

  function automatic logic [DATA_MSB:DATA_LSB] word_data(input logic [DEF_DAT_WIDTH-1:0] w);
    return w[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/nmr_sram_rd_tag.sv
// Read-return tracker: an RD_LAT-deep shift register of {valid, owner} tags
// loaded from the registered SRAM command, steering read-valid to the issuer.
module nmr_sram_rd_tag
  import nmr_bstrm_pkg::*;
#(
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_vld,
  input  owner_e push_own,
  output logic   h_rd_vld,
  output logic   e_rd_vld
);

  rd_tag_t tag_q [RD_LAT];

  // Stage 0 is loaded one edge after the chip-select cycle, so the last
  // stage lines up with the cycle the SRAM presents its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '{vld: 1'b0, own: OWN_HOST};
      end
    end else begin
      tag_q[0] <= '{vld: push_vld, own: push_own};
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign h_rd_vld = tag_q[RD_LAT-1].vld & (tag_q[RD_LAT-1].own == OWN_HOST);
  assign e_rd_vld = tag_q[RD_LAT-1].vld & (tag_q[RD_LAT-1].own == OWN_ENG);

endmodule

// File: rtl/nmr_sram_arb.sv
// Single-port arbiter between the host loader and the NMR bitstream engine
// for the bitstream SRAM; one registered access per cycle.
module nmr_sram_arb
  import nmr_bstrm_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int SRAM_DAT_WIDTH    = DEF_DAT_WIDTH,
  parameter int SRAM_BYTEEN_WIDTH = DEF_BYTEEN_WIDTH,
  parameter int RD_LAT            = DEF_RD_LAT
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         LOCK,
  input  logic                         H_REQ,
  input  logic                         H_WR,
  input  logic [SRAM_ADDR_WIDTH-1:0]   H_ADDR,
  input  logic [SRAM_DAT_WIDTH-1:0]    H_WR_DAT,
  input  logic [SRAM_BYTEEN_WIDTH-1:0] H_BYTEEN,
  output logic                         H_GNT,
  output logic                         H_RD_VLD,
  output logic                         H_BLOCKED,
  input  logic                         E_REQ,
  input  logic [SRAM_ADDR_WIDTH-1:0]   E_ADDR,
  output logic                         E_GNT,
  output logic                         E_RD_VLD,
  output logic [SRAM_DAT_WIDTH-1:0]    RD_DAT,
  output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
  output logic                         SRAM_CS,
  output logic                         SRAM_CLKEN,
  output logic                         SRAM_WR,
  output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
  output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
  input  logic [SRAM_DAT_WIDTH-1:0]    SRAM_RD_DAT
);

  owner_e last_grant;
  logic   e_elig;
  logic   h_elig;
  logic   sel_eng;
  logic   sel_host;

  // Handshake: a requester holds REQ with a stable command until it sees GNT
  // for one cycle; the GNT=1 term below keeps that held request from being
  // issued twice, so it must drop REQ or present the next command next edge.
  assign e_elig   = E_REQ & ~E_GNT;
  assign h_elig   = H_REQ & ~H_GNT & ~LOCK;
  assign sel_eng  = e_elig & (~h_elig | (last_grant == OWN_HOST));
  assign sel_host = h_elig & ~sel_eng;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      H_GNT       <= 1'b0;
      E_GNT       <= 1'b0;
      H_BLOCKED   <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_CS     <= 1'b0;
      SRAM_CLKEN  <= 1'b0;
      SRAM_WR     <= 1'b0;
      SRAM_WR_DAT <= '0;
      SRAM_BYTEEN <= '1;
      last_grant  <= OWN_HOST;
    end else begin
      SRAM_CLKEN <= 1'b1;
      H_BLOCKED  <= H_REQ & LOCK;
      H_GNT      <= sel_host;
      E_GNT      <= sel_eng;
      SRAM_CS    <= sel_eng | sel_host;
      // Idle cycles leave address, data and byte enables untouched.
      if (sel_eng) begin
        SRAM_ADDR   <= E_ADDR;
        SRAM_WR     <= 1'b0;
        SRAM_BYTEEN <= '1;
        last_grant  <= OWN_ENG;
      end else if (sel_host) begin
        SRAM_ADDR   <= H_ADDR;
        SRAM_WR     <= H_WR;
        SRAM_WR_DAT <= H_WR_DAT;
        SRAM_BYTEEN <= H_BYTEEN;
        last_grant  <= OWN_HOST;
      end else begin
        SRAM_WR <= 1'b0;
      end
    end
  end

  nmr_sram_rd_tag #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push_vld (SRAM_CS & ~SRAM_WR),
    .push_own (E_GNT ? OWN_ENG : OWN_HOST),
    .h_rd_vld (H_RD_VLD),
    .e_rd_vld (E_RD_VLD)
  );

  assign RD_DAT = SRAM_RD_DAT;

  a_one_grant : assert property (@(posedge CLK) disable iff (!RST_N)
    !(H_GNT && E_GNT));
  a_cs_matches_gnt : assert property (@(posedge CLK) disable iff (!RST_N)
    SRAM_CS == (H_GNT || E_GNT));
  a_eng_read_only : assert property (@(posedge CLK) disable iff (!RST_N)
    E_GNT |-> (!SRAM_WR && (SRAM_BYTEEN == '1)));

endmodule

// File: tb/tb_nmr_sram_arb.sv
// Bench for nmr_sram_arb: directed table and sequences, then random traffic
// against a rule-level arbitration model and a shadow-memory scoreboard.
module tb_nmr_sram_arb;
  import nmr_bstrm_pkg::*;

  localparam int AW = 8;
  localparam int DW = 128;
  localparam int BW = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT0 (RD_LAT=2) signals
  logic          lock, h_req, h_wr, e_req;
  logic [AW-1:0] h_addr, e_addr;
  logic [DW-1:0] h_wr_dat;
  logic [BW-1:0] h_byteen;
  logic          h_gnt, h_rd_vld, h_blocked, e_gnt, e_rd_vld;
  logic [DW-1:0] rd_dat, sram_wr_dat, sram_rd_dat;
  logic [AW-1:0] sram_addr;
  logic          sram_cs, sram_clken, sram_wr;
  logic [BW-1:0] sram_byteen;

  // DUT1 (RD_LAT=1) signals, engine-only traffic
  logic          e1_req;
  logic [AW-1:0] e1_addr;
  logic          u1_h_gnt, u1_h_rd_vld, u1_h_blocked, u1_e_gnt, u1_e_rd_vld;
  logic [DW-1:0] u1_rd_dat, u1_wr_dat, u1_sram_rd_dat;
  logic [AW-1:0] u1_addr;
  logic          u1_cs, u1_clken, u1_wr;
  logic [BW-1:0] u1_byteen;

  nmr_sram_arb #(.RD_LAT(2)) dut0 (
    .CLK(clk), .RST_N(rst_n), .LOCK(lock),
    .H_REQ(h_req), .H_WR(h_wr), .H_ADDR(h_addr), .H_WR_DAT(h_wr_dat), .H_BYTEEN(h_byteen),
    .H_GNT(h_gnt), .H_RD_VLD(h_rd_vld), .H_BLOCKED(h_blocked),
    .E_REQ(e_req), .E_ADDR(e_addr), .E_GNT(e_gnt), .E_RD_VLD(e_rd_vld),
    .RD_DAT(rd_dat), .SRAM_ADDR(sram_addr), .SRAM_CS(sram_cs), .SRAM_CLKEN(sram_clken),
    .SRAM_WR(sram_wr), .SRAM_WR_DAT(sram_wr_dat), .SRAM_BYTEEN(sram_byteen),
    .SRAM_RD_DAT(sram_rd_dat)
  );

  nmr_sram_arb #(.RD_LAT(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .LOCK(1'b0),
    .H_REQ(1'b0), .H_WR(1'b0), .H_ADDR(8'h00), .H_WR_DAT('0), .H_BYTEEN('1),
    .H_GNT(u1_h_gnt), .H_RD_VLD(u1_h_rd_vld), .H_BLOCKED(u1_h_blocked),
    .E_REQ(e1_req), .E_ADDR(e1_addr), .E_GNT(u1_e_gnt), .E_RD_VLD(u1_e_rd_vld),
    .RD_DAT(u1_rd_dat), .SRAM_ADDR(u1_addr), .SRAM_CS(u1_cs), .SRAM_CLKEN(u1_clken),
    .SRAM_WR(u1_wr), .SRAM_WR_DAT(u1_wr_dat), .SRAM_BYTEEN(u1_byteen),
    .SRAM_RD_DAT(u1_sram_rd_dat)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] s;
    s = (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    return {s, ~s, s ^ 32'h1234_5678, 32'(a)};
  endfunction

  // SRAM models: data appears RD_LAT cycles after the chip-select cycle
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] rp0 [2];
  assign sram_rd_dat = rp0[1];
  initial begin
    for (int i = 0; i < 256; i++) mem0[i] = init_word(i);
    rp0[0] = '0;
    rp0[1] = '0;
    forever begin
      @(posedge clk);
      rp0[1] = rp0[0];
      if (sram_cs && sram_clken) begin
        if (sram_wr) begin
          for (int b = 0; b < BW; b++)
            if (sram_byteen[b]) mem0[sram_addr][b*8 +: 8] = sram_wr_dat[b*8 +: 8];
        end else begin
          rp0[0] = mem0[sram_addr];
        end
      end
    end
  end

  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] rp1;
  assign u1_sram_rd_dat = rp1;
  initial begin
    for (int i = 0; i < 256; i++) mem1[i] = init_word(i);
    rp1 = '0;
    forever begin
      @(posedge clk);
      if (u1_cs && u1_clken && !u1_wr) rp1 = mem1[u1_addr];
    end
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] exp_q [$];
  int            due_q [$];
  owner_e        own_q [$];
  logic [DW-1:0] exp1_q [$];
  int            due1_q [$];

  task automatic chk_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic exp_read(input owner_e own, input logic [AW-1:0] a);
    exp_q.push_back(shadow[a]);
    due_q.push_back(cyc + 2);
    own_q.push_back(own);
  endtask

  task automatic check_returns();
    bit due_now, due1_now;
    due_now = (due_q.size() > 0) && (due_q[0] == cyc);
    chk_b("h_rd_vld", h_rd_vld, due_now && own_q[0] == OWN_HOST);
    chk_b("e_rd_vld", e_rd_vld, due_now && own_q[0] == OWN_ENG);
    if (due_now) begin
      chk_w("rd_dat", rd_dat, exp_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
      void'(own_q.pop_front());
    end
    due1_now = (due1_q.size() > 0) && (due1_q[0] == cyc);
    chk_b("u1_e_rd_vld", u1_e_rd_vld, due1_now);
    chk_b("u1_h_rd_vld", u1_h_rd_vld, 1'b0);
    if (due1_now) begin
      chk_w("u1_rd_dat", u1_rd_dat, exp1_q[0]);
      void'(exp1_q.pop_front());
      void'(due1_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_returns();
  endtask

  typedef struct packed {
    bit lock, h, e, xh, xe;
  } vec_t;

  function automatic vec_t mk(input bit l, input bit h, input bit e, input bit xh, input bit xe);
    vec_t v;
    v.lock = l; v.h = h; v.e = e; v.xh = xh; v.xe = xe;
    return v;
  endfunction

  localparam logic [DW-1:0] WDAT = 128'h0C00_0000_0000_0000_0000_0000_0000_000A;

  initial begin
    vec_t tv [16];
    bit m_hg, m_eg, e_el, h_el, win_e, win_h;
    owner_e m_last;
    logic [AW-1:0] n;

    tv[0]  = mk(0, 1, 1, 0, 1);  tv[1]  = mk(0, 1, 1, 1, 0);
    tv[2]  = mk(0, 1, 1, 0, 1);  tv[3]  = mk(0, 1, 1, 1, 0);
    tv[4]  = mk(1, 1, 1, 0, 1);  tv[5]  = mk(1, 1, 1, 0, 0);
    tv[6]  = mk(1, 1, 1, 0, 1);  tv[7]  = mk(0, 1, 1, 1, 0);
    tv[8]  = mk(0, 0, 0, 0, 0);  tv[9]  = mk(0, 1, 0, 1, 0);
    tv[10] = mk(0, 1, 1, 0, 1);  tv[11] = mk(0, 0, 1, 0, 0);
    tv[12] = mk(0, 0, 1, 0, 1);  tv[13] = mk(0, 0, 0, 0, 0);
    tv[14] = mk(0, 1, 1, 1, 0);  tv[15] = mk(0, 1, 1, 0, 1);

    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    rst_n = 1'b0; lock = 1'b0; h_req = 1'b0; h_wr = 1'b0; h_addr = '0;
    h_wr_dat = '0; h_byteen = '1; e_req = 1'b0; e_addr = '0;
    e1_req = 1'b0; e1_addr = '0;

    // reset values
    repeat (3) tick();
    chk_b("rst_h_gnt", h_gnt, 1'b0);
    chk_b("rst_e_gnt", e_gnt, 1'b0);
    chk_b("rst_blocked", h_blocked, 1'b0);
    chk_b("rst_cs", sram_cs, 1'b0);
    chk_b("rst_clken", sram_clken, 1'b0);
    chk_b("rst_wr", sram_wr, 1'b0);
    chk_w("rst_addr", 128'(sram_addr), 128'd0);
    chk_w("rst_wr_dat", sram_wr_dat, 128'd0);
    chk_w("rst_byteen", 128'(sram_byteen), 128'hFFFF);
    rst_n = 1'b1;
    #1;
    chk_b("clken_before_edge", sram_clken, 1'b0);
    tick();
    chk_b("clken_after_edge", sram_clken, 1'b1);
    chk_b("idle_cs", sram_cs, 1'b0);
    chk_b("u1_clken", u1_clken, 1'b1);

    // host write then read-back of address 3
    h_req = 1'b1; h_wr = 1'b1; h_addr = 8'd3; h_wr_dat = WDAT; h_byteen = '1;
    tick();
    chk_b("wr_h_gnt", h_gnt, 1'b1);
    chk_b("wr_cs", sram_cs, 1'b1);
    chk_b("wr_wr", sram_wr, 1'b1);
    chk_w("wr_addr", 128'(sram_addr), 128'd3);
    chk_w("wr_dat", sram_wr_dat, WDAT);
    chk_w("wr_byteen", 128'(sram_byteen), 128'hFFFF);
    shadow[3] = WDAT;
    h_wr = 1'b0;
    tick();
    chk_b("held_no_regrant", h_gnt, 1'b0);
    tick();
    chk_b("rd_h_gnt", h_gnt, 1'b1);
    chk_b("rd_wr", sram_wr, 1'b0);
    chk_w("rd_addr", 128'(sram_addr), 128'd3);
    exp_read(OWN_HOST, 8'd3);
    h_req = 1'b0;
    repeat (4) tick();
    chk_w("rd_drained", 128'(due_q.size()), 128'd0);

    // table: round-robin, lock, tie breaking from a fresh reset
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    for (int i = 0; i < 16; i++) begin
      lock = tv[i].lock; h_req = tv[i].h; h_wr = 1'b0; h_addr = 8'(8'h40 + i);
      e_req = tv[i].e; e_addr = 8'(8'h10 + i);
      tick();
      chk_b("tbl_h_gnt", h_gnt, tv[i].xh);
      chk_b("tbl_e_gnt", e_gnt, tv[i].xe);
      chk_b("tbl_cs", sram_cs, tv[i].xh | tv[i].xe);
      chk_b("tbl_blocked", h_blocked, tv[i].h & tv[i].lock);
      if (tv[i].xh) begin
        chk_w("tbl_h_addr", 128'(sram_addr), 128'(h_addr));
        exp_read(OWN_HOST, h_addr);
      end
      if (tv[i].xe) begin
        chk_w("tbl_e_addr", 128'(sram_addr), 128'(e_addr));
        exp_read(OWN_ENG, e_addr);
      end
    end
    lock = 1'b0; h_req = 1'b0; e_req = 1'b0;
    repeat (4) tick();

    // LOCK: engine reads 0..11 while the host waits
    lock = 1'b1; h_req = 1'b1; h_wr = 1'b0; h_addr = 8'h20; e_req = 1'b1; n = '0; e_addr = n;
    for (int k = 0; k < 23; k++) begin
      tick();
      chk_b("lk_e_gnt", e_gnt, (k % 2) == 0);
      chk_b("lk_h_gnt", h_gnt, 1'b0);
      chk_b("lk_blocked", h_blocked, 1'b1);
      if ((k % 2) == 0) begin
        chk_w("lk_addr", 128'(sram_addr), 128'(n));
        exp_read(OWN_ENG, n);
        n = n + 8'd1;
        e_addr = n;
        if (n == 8'd12) e_req = 1'b0;
      end
    end
    lock = 1'b0;
    tick();
    chk_b("unlock_h_gnt", h_gnt, 1'b1);
    chk_b("unlock_blocked", h_blocked, 1'b0);
    chk_w("unlock_addr", 128'(sram_addr), 128'h20);
    exp_read(OWN_HOST, 8'h20);
    h_req = 1'b0;
    repeat (4) tick();

    // reset with an engine read in flight: no read-valid may appear
    e_req = 1'b1; e_addr = 8'd5;
    tick();
    chk_b("inflight_gnt", e_gnt, 1'b1);
    e_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk_b("async_cs", sram_cs, 1'b0);
    chk_b("async_clken", sram_clken, 1'b0);
    chk_w("async_byteen", 128'(sram_byteen), 128'hFFFF);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    e_req = 1'b1; e_addr = 8'd6;
    tick();
    chk_b("post_rst_gnt", e_gnt, 1'b1);
    exp_read(OWN_ENG, 8'd6);
    e_req = 1'b0;
    repeat (4) tick();

    // RD_LAT=1 instance: back-to-back engine reads
    e1_req = 1'b1; n = 8'h30; e1_addr = n;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk_b("u1_e_gnt", u1_e_gnt, (k % 2) == 0);
      if ((k % 2) == 0) begin
        chk_w("u1_addr", 128'(u1_addr), 128'(n));
        exp1_q.push_back(init_word(int'(n)));
        due1_q.push_back(cyc + 1);
        n = n + 8'd1;
        e1_addr = n;
      end
    end
    e1_req = 1'b0;
    repeat (3) tick();
    chk_w("u1_drained", 128'(due1_q.size()), 128'd0);
    chk_b("u1_h_gnt", u1_h_gnt, 1'b0);
    chk_b("u1_blocked", u1_h_blocked, 1'b0);
    chk_b("u1_wr", u1_wr, 1'b0);
    chk_w("u1_wr_dat", u1_wr_dat, 128'd0);
    chk_w("u1_byteen", 128'(u1_byteen), 128'hFFFF);

    // random traffic against the rule-level model
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    m_hg = 1'b0; m_eg = 1'b0; m_last = OWN_HOST;
    for (int c = 0; c < 3000; c++) begin
      e_el  = e_req && !m_eg;
      h_el  = h_req && !m_hg && !lock;
      win_e = e_el && (!h_el || m_last == OWN_HOST);
      win_h = h_el && !win_e;
      tick();
      chk_b("rnd_h_gnt", h_gnt, win_h);
      chk_b("rnd_e_gnt", e_gnt, win_e);
      chk_b("rnd_cs", sram_cs, win_h | win_e);
      chk_b("rnd_blocked", h_blocked, h_req & lock);
      if (win_e) begin
        chk_w("rnd_e_addr", 128'(sram_addr), 128'(e_addr));
        chk_b("rnd_e_wr", sram_wr, 1'b0);
        chk_w("rnd_e_byteen", 128'(sram_byteen), 128'hFFFF);
        exp_read(OWN_ENG, e_addr);
        m_last = OWN_ENG;
      end
      if (win_h) begin
        chk_w("rnd_h_addr", 128'(sram_addr), 128'(h_addr));
        chk_b("rnd_h_wr", sram_wr, h_wr);
        if (h_wr) begin
          chk_w("rnd_wr_dat", sram_wr_dat, h_wr_dat);
          chk_w("rnd_byteen", 128'(sram_byteen), 128'(h_byteen));
          for (int b = 0; b < BW; b++)
            if (h_byteen[b]) shadow[h_addr][b*8 +: 8] = h_wr_dat[b*8 +: 8];
        end else begin
          exp_read(OWN_HOST, h_addr);
        end
        m_last = OWN_HOST;
      end
      m_hg = win_h;
      m_eg = win_e;
      if ($urandom_range(0, 31) == 0) lock = ~lock;
      if (win_h || !h_req) begin
        if ($urandom_range(0, 3) != 0) begin
          h_req = 1'b1;
          h_wr = 1'($urandom_range(0, 1));
          h_addr = 8'($urandom_range(0, 255));
          h_wr_dat = {$urandom(), $urandom(), $urandom(), $urandom()};
          h_byteen = 16'($urandom());
        end else begin
          h_req = 1'b0;
        end
      end
      if (win_e || !e_req) begin
        e_req = ($urandom_range(0, 3) != 0);
        e_addr = 8'($urandom_range(0, 255));
      end
    end
    h_req = 1'b0; e_req = 1'b0; lock = 1'b0;
    repeat (4) tick();
    chk_w("rnd_drained", 128'(due_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
